// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data memory access unit.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] DMEM_ALIGN_MASK = 2'b11;

    // Timeout counter width; a zero timeout still needs a 1-bit counter.
    function automatic int unsigned ctr_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dmem_access_unit_timeout_ctr.sv
// Cycle counter for a pending memory access; flags expiry on the last allowed cycle.
module dmem_timeout_ctr
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = ctr_width(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Only raised while enabled, so a cycle with an ack can never expire.
    always_comb begin
        expired = (TIMEOUT != 0) && enable && (count == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: req/ack handshake, pipeline stall,
// load-data register, misalignment and timeout detection.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] ALUres_i,
    input  logic [DATA_W-1:0] MEMWriteData_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ReadData_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    state_t state, state_nxt;
    logic   access;
    logic   aligned;
    logic   ctr_clear;
    logic   ctr_en;
    logic   expired;

    dmem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .expired(expired)
    );

    always_comb begin
        access    = MemRead_i | MemWrite_i;
        aligned   = (ALUres_i[1:0] & DMEM_ALIGN_MASK) == 2'b00;
        state_nxt = state;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall_o   = 1'b1;
                    ctr_clear = aligned;
                    state_nxt = aligned ? BUSY : DONE;
                end
            end
            BUSY: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                ctr_en    = !mem_ack_i;
                if (mem_ack_i || expired) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Stall must release while reset is held even if a request is still presented.
        stall_o = stall_o & rst_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ReadData_o  <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            misalign_o <= (state == IDLE) && access && !aligned;
            timeout_o  <= expired;
            if ((state == IDLE) && access && aligned) begin
                mem_addr_o  <= {ALUres_i[ADDR_W-1:2], 2'b00};
                mem_wdata_o <= MEMWriteData_i;
                mem_we_o    <= MemWrite_i;
            end
            if ((state == BUSY) && !mem_we_o) begin
                if (mem_ack_i) begin
                    ReadData_o <= mem_rdata_i;
                end else if (expired) begin
                    ReadData_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: directed accesses push expected requests
// and completions; a negedge monitor pops and compares as the DUT presents them.
module tb_dmem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] ALUres_i, MEMWriteData_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] ReadData_o;
    logic        misalign_o, timeout_o;

    dmem_access_unit #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .ALUres_i      (ALUres_i),
        .MEMWriteData_i(MEMWriteData_i),
        .stall_o       (stall_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .ReadData_o    (ReadData_o),
        .misalign_o    (misalign_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        int          stall;
        int          req;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int checks   = 0;
    int failures = 0;

    int          ack_after = 0;
    logic [31:0] rdata_val = '0;
    logic        spur_ack  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: acks in the ack_after-th request cycle (0 = never).
    initial begin
        int k;
        k = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o) k++;
            else k = 0;
            mem_ack_i   = spur_ack || (mem_req_o && ack_after != 0 && k == ack_after);
            mem_rdata_i = rdata_val;
        end
    end

    // Monitor: checks each new request and each completion (stall falling).
    initial begin
        logic  prev_stall, prev_req;
        int    stall_cnt, req_cnt;
        req_t  r;
        done_t d;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        stall_cnt  = 0;
        req_cnt    = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev_stall = 1'b0;
                prev_req   = 1'b0;
                stall_cnt  = 0;
                req_cnt    = 0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_addr", mem_addr_o, r.addr);
                        chk("req_we", 32'(mem_we_o), 32'(r.we));
                        chk("req_wdata", mem_wdata_o, r.wdata);
                    end
                end
                if (stall_o) stall_cnt++;
                if (mem_req_o) req_cnt++;
                if (prev_stall && !stall_o) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_rdata", ReadData_o, d.rdata);
                        chk("done_misalign", 32'(misalign_o), 32'(d.mis));
                        chk("done_timeout", 32'(timeout_o), 32'(d.to));
                        chk("done_stall_cycles", 32'(stall_cnt), 32'(d.stall));
                        chk("done_req_cycles", 32'(req_cnt), 32'(d.req));
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end else if (misalign_o || timeout_o) begin
                    chk("stray_pulse", {30'd0, misalign_o, timeout_o}, 32'd0);
                end
                prev_stall = stall_o;
                prev_req   = mem_req_o;
            end
        end
    end

    // Presents one EX/MEM instruction and holds it until the DONE cycle ends.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack, input logic [31:0] rdata,
                             input logic [31:0] e_rdata, input logic e_mis, input logic e_to,
                             input int e_stall, input int e_req);
        int n;
        if (e_req > 0) req_q.push_back('{addr: addr, we: wr, wdata: wdata});
        done_q.push_back('{rdata: e_rdata, mis: e_mis, to: e_to, stall: e_stall, req: e_req});
        MemRead_i      = rd;
        MemWrite_i     = wr;
        ALUres_i       = addr;
        MEMWriteData_i = wdata;
        ack_after      = ack;
        rdata_val      = rdata;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (stall_o && n < 64);
        if (n >= 64) chk("access_cycle_budget", 32'(n), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic go_idle();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i          = 1'b0;
        MemRead_i      = 1'b0;
        MemWrite_i     = 1'b0;
        ALUres_i       = '0;
        MEMWriteData_i = '0;
        #12;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", ReadData_o, 32'd0);
        chk("rst_pulses", {30'd0, misalign_o, timeout_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Load, ack in 2nd BUSY cycle
        do_access(1, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 3, 2);
        go_idle();
        // Store, ack in 1st BUSY cycle; read data untouched
        do_access(0, 1, 32'h10, 32'h12345678, 1, 32'h0, 32'hDEADBEEF, 0, 0, 2, 1);
        go_idle();
        // Misaligned load: no request
        do_access(1, 0, 32'h42, 32'h0, 1, 32'h77777777, 32'hDEADBEEF, 1, 0, 1, 0);
        go_idle();
        // Misaligned store
        do_access(0, 1, 32'h107, 32'h9, 1, 32'h0, 32'hDEADBEEF, 1, 0, 1, 0);
        go_idle();
        // Read and write together: write wins
        do_access(1, 1, 32'h20, 32'h55, 1, 32'h66666666, 32'hDEADBEEF, 0, 0, 2, 1);
        go_idle();
        // Timeout on load, no ack
        do_access(1, 0, 32'h80, 32'h0, 0, 32'hA5A5A5A5, 32'h0, 0, 1, 5, 4);
        go_idle();
        // Ack coincides with expiry: ack wins
        do_access(1, 0, 32'h84, 32'h0, 4, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 5, 4);
        go_idle();
        // Back-to-back load then store, no idle between
        do_access(1, 0, 32'h100, 32'h0, 1, 32'h11112222, 32'h11112222, 0, 0, 2, 1);
        do_access(0, 1, 32'h104, 32'h33334444, 3, 32'h0, 32'h11112222, 0, 0, 4, 3);
        go_idle();

        // Reset in the middle of a BUSY load
        req_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        MemRead_i = 1'b1;
        ALUres_i  = 32'h200;
        MEMWriteData_i = 32'h0;
        ack_after = 0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        chk("busy_req_before_rst", 32'(mem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req_o), 32'd0);
        chk("abort_stall", 32'(stall_o), 32'd0);
        chk("abort_rdata", ReadData_o, 32'd0);
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_req", 32'(mem_req_o), 32'd0);
        chk("post_rst_stall", 32'(stall_o), 32'd0);
        // Spurious ack while idle
        rdata_val = 32'hFFFFFFFF;
        spur_ack  = 1'b1;
        @(posedge clk_i);
        #2;
        spur_ack = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("spur_ack_rdata", ReadData_o, 32'd0);
        chk("spur_ack_req", 32'(mem_req_o), 32'd0);
        chk("spur_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        // Normal load after recovery
        do_access(1, 0, 32'h300, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 0, 2, 1);
        go_idle();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
